// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clock-enable generator: default widths,
// the minimum legal divisor, the per-channel state enum and the divisor clamp.
// Latency: n/a (types only). Backpressure: n/a.
package clk_en_pkg;

  localparam int CW_DEF  = 20;
  localparam int DIV_MIN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Divisors below DIV_MIN cannot produce both a low and a high phase,
  // so they are raised to DIV_MIN. Operates on 32 bits so any CW <= 32 fits.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: period counter, shadow config, IDLE/RUN control.
// Latency: start/sync/wrap effects visible one clk later; all outputs are flops.
// Backpressure: none; config writes are always accepted (last write wins).
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   step_i                 cascade strobe (previous channel's tick), used when src=1
//   en_i, sync_i           run request level, phase-align restart pulse
//   wr_i, wr_div_i, wr_src_i  config write for this channel
//   clk_out_o, tick_o, running_o, pending_o  registered channel outputs
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_div_i,
  input  logic          wr_src_i,
  output logic          clk_out_o,
  output logic          tick_o,
  output logic          running_o,
  output logic          pending_o
);

  typedef struct packed {
    logic [CW-1:0] div;
    logic          src;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{div: CW'(clamp_div(32'(DEF_DIV))), src: 1'b0};

  chan_state_e   state_q, state_d;
  cfg_t          act_q, act_d;
  cfg_t          shd_q, shd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          clk_out_q, clk_out_d;

  cfg_t wr_cfg;
  cfg_t apply_cfg;
  logic step;
  logic wrap;

  assign wr_cfg = '{div: CW'(clamp_div(32'(wr_div_i))), src: wr_src_i};
  // A write landing on the apply cycle takes effect at that apply.
  assign apply_cfg = wr_i ? wr_cfg : shd_q;

  assign step = act_q.src ? step_i : 1'b1;
  assign wrap = step && (cnt_q == act_q.div - 1'b1);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    shd_d   = shd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;

    if (wr_i) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end

    if (sync_i && (state_q == ST_RUN || en_i)) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      tick_d  = 1'b1;
      act_d   = apply_cfg;
      shd_d   = apply_cfg;
      pend_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      // Idle channels adopt new config at once so nothing stays pending.
      cnt_d  = '0;
      act_d  = apply_cfg;
      shd_d  = apply_cfg;
      pend_d = 1'b0;
      if (en_i) begin
        state_d = ST_RUN;
        tick_d  = 1'b1;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      act_d  = apply_cfg;
      shd_d  = apply_cfg;
      pend_d = 1'b0;
      // A stop only takes effect here, so the high phase is never cut short;
      // re-raising en_i before this point simply cancels it.
      if (en_i) begin
        tick_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Low phase first: high once the count reaches div - floor(div/2).
    clk_out_d = (state_d == ST_RUN) && (cnt_d >= (act_d.div - (act_d.div >> 1)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      act_q     <= DEF_CFG;
      shd_q     <= DEF_CFG;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign running_o = (state_q == ST_RUN);
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator with cascading and sync.
// Latency: one clk from ch_en/sync/cfg to outputs; +1 clk per cascaded stage.
// Backpressure: none; cfg writes to channels >= NCH are dropped.
//
// Ports:
//   clk, rst                       system clock, asynchronous active-high reset
//   cfg_wr, cfg_ch, cfg_div, cfg_src  one-cycle config write to one channel
//   ch_en [NCH]                    per-channel run request
//   sync                           restart all running/enabled channels in phase
//   clk_out, tick, running, pending [NCH]  per-channel registered outputs
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_wr,
  input  logic [ch_idx_w(NCH)-1:0]    cfg_ch,
  input  logic [CW-1:0]               cfg_div,
  input  logic                        cfg_src,
  input  logic [NCH-1:0]              ch_en,
  input  logic                        sync,
  output logic [NCH-1:0]              clk_out,
  output logic [NCH-1:0]              tick,
  output logic [NCH-1:0]              running,
  output logic [NCH-1:0]              pending
);

  localparam int CHW = ch_idx_w(NCH);

  logic [NCH-1:0] chan_wr;
  logic [NCH-1:0] chan_src;
  logic [NCH-1:0] casc_step;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign chan_wr[i] = cfg_wr && (cfg_ch == CHW'(i));

    // Channel 0 has no upstream channel, so it always counts clk cycles.
    if (i == 0) begin : g_first
      assign chan_src[i]  = 1'b0;
      assign casc_step[i] = 1'b0;
    end else begin : g_casc
      assign chan_src[i]  = cfg_src;
      assign casc_step[i] = tick[i-1];
    end

    clk_en_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .step_i    (casc_step[i]),
      .en_i      (ch_en[i]),
      .sync_i    (sync),
      .wr_i      (chan_wr[i]),
      .wr_div_i  (cfg_div),
      .wr_src_i  (chan_src[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .running_o (running[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel, runtime-programmable clock-enable generator; successor to the fixed-ratio divider chain. From one system clock it produces NCH independent divided outputs. Each output is a registered square wave plus a one-cycle tick strobe, both in the clk domain with no derived clocks. Per channel it supports a 2..2^CW-1 divisor, glitch-free divisor change and start/stop at period boundaries, optional cascading from the previous channel's tick (e.g. 24 MHz → 1 MHz → 1 Hz), and a global phase-align sync.

## Interface
Parameters:
- NCH, 4, number of channels (1..16)
- CW, 20, divisor/counter width
- DEF_DIV, 2, divisor loaded into every channel at reset (clamped to ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cfg_wr  in  1  one-cycle config write strobe
- cfg_ch  in  $clog2(NCH) (min 1)  target channel; out-of-range writes are ignored
- cfg_div  in  CW  new divisor; 0 and 1 are clamped to 2
- cfg_src  in  1  0: channel counts clk cycles; 1: channel counts ticks of channel ch-1 (forced to 0 for ch 0)
- ch_en  in  NCH  per-channel run request (level)
- sync  in  1  one-cycle pulse: restart all running channels in phase
- clk_out  out  NCH  divided square wave per channel
- tick  out  NCH  one-cycle strobe per period
- running  out  NCH  channel is active
- pending  out  NCH  a written config has not yet been applied

## Operation
- Per-channel state: active div/src, shadow div/src, cnt[CW-1:0], running, pending.
- Step condition: src=0 means every clk cycle; src=1 means cycles where tick[ch-1]=1.
- Counting: on each step while running, cnt <= (cnt==div-1) ? 0 : cnt+1. Entering 0 is a wrap.
- clk_out = running && (cnt >= div - (div>>1)). The low phase comes first.
  - Even div: 50 % duty.
  - Odd div: high for div>>1 steps, low for div-(div>>1) steps.
- tick is registered and asserts for exactly one clk cycle, in the cycle after a wrap or start.
- Config write: shadow <= {clamped cfg_div, cfg_src}; pending=1.
  - Applied at the next wrap, or immediately if the channel is idle; pending clears on apply.
  - A second write while pending overwrites the shadow (last write wins).
- Channel state machine has two states, IDLE and RUN:
  - IDLE→RUN: ch_en=1. Next cycle running=1, cnt=0, tick=1, pending applied.
  - RUN→IDLE: ch_en=0 is sampled. The current period completes, then at the wrap running=0, cnt=0, and no tick is issued.
  - ch_en reasserted before that wrap: the stop is cancelled with no disturbance.
- sync: every RUN channel and every IDLE channel with ch_en=1 restarts next cycle with cnt=0 and tick=1, applying pending.
  - sync is the only event allowed to truncate a high phase.
- Priority: rst > sync > wrap/apply > step.
- A cfg_wr coinciding with a wrap on the same channel is applied at that wrap.

## Timing
- Reset values:
  - cnt=0, clk_out=0, tick=0, running=0, pending=0.
  - Active and shadow div=max(DEF_DIV,2), src=0.
- Start latency: ch_en rising at cycle n → running, tick at n+1; first clk_out rise at n+1+div-(div>>1).
- Cascade: each cascaded stage adds one clk of tick latency relative to its source; period = product of divisors.
- rst mid-period returns all outputs to reset values immediately; no runt beyond the asynchronous reset edge.
- All outputs are driven directly from flops; no combinational input→output paths.

## Structure
- Package clk_en_pkg holds:
  - CW default, DIV_MIN=2
  - Channel config struct {div[CW-1:0], src}
  - Clamp function
- Sub-module clk_en_chan: one channel (counter, shadow, start/stop state machine, outputs). Inputs are step, ch_en, sync and cfg, instantiated NCH times via generate.
- The top level does cfg decode and tick[ch-1] → step wiring.

## Test plan
- Reset, ch_en[0]=1, div=2 → tick every 2 cycles, clk_out[0] toggles 0,1,0,1; running[0]=1 one cycle after ch_en.
- div=5 on ch1 → clk_out low 3 / high 2, tick period 5; write 0 → behaves as div=2.
- While running with div=16, write div=24 at cnt=3 → pending=1 until the wrap, first 24-cycle period starts exactly after the 16-cycle one, no runt.
- Cascade: ch0 div=24, ch1 src=1 div=1000, ch2 src=1 div=1000 → ch2 tick every 24,000,000 clk; measure ch1 period=24,000.
- Drop ch_en[0] mid high phase → clk_out completes the period, then running=0, clk_out=0, and no extra tick.
- Channels at div 3/4/7 free-running, pulse sync → all three tick in the same cycle. Assert rst mid-run → all outputs 0 asynchronously.
